// File: rtl/musa_fetch_pkg.sv
// rtl/musa_fetch_pkg.sv - shared types and constants for the MUSA fetch stage
package musa_fetch_pkg;

    localparam int unsigned INSTR_W    = 32;
    localparam int unsigned OPCODE_MSB = 31;
    localparam int unsigned OPCODE_LSB = 26;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        PC_SEQ    = 2'b00,
        PC_BRANCH = 2'b01,
        PC_JUMP   = 2'b10,
        PC_RET    = 2'b11
    } pc_src_e;

    typedef enum logic [1:0] {
        ST_BOOT   = 2'b00,
        ST_FETCH  = 2'b01,
        ST_HALTED = 2'b10
    } fetch_state_e;

    // Decode opcode field of a fetched instruction word
    function automatic logic [OPCODE_MSB-OPCODE_LSB:0] opcode_of(input logic [INSTR_W-1:0] word);
        return word[OPCODE_MSB:OPCODE_LSB];
    endfunction

    // pc+4 plus the sign-extended word offset; wraps modulo 2^32
    function automatic logic [31:0] branch_addr(input logic [31:0] pc4, input logic [15:0] offset);
        return pc4 + {{14{offset[15]}}, offset, 2'b00};
    endfunction

    // Region-relative jump: keeps the top nibble of pc+4
    function automatic logic [31:0] jump_addr(input logic [31:0] pc4, input logic [25:0] index);
        return {pc4[31:28], index, 2'b00};
    endfunction

endpackage

// File: rtl/fetch_ras.sv
// rtl/fetch_ras.sv - circular return-address stack with count and sticky error flags
module fetch_ras
    import musa_fetch_pkg::*;
#(
    parameter int unsigned DEPTH    = 8,
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        push,
    input  logic        pop,
    input  logic [31:0] push_data,
    output logic [31:0] top,
    output logic        overflow,
    output logic        underflow
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    logic [31:0]   mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] top_idx;
    logic [CW-1:0] count;
    logic          full;
    logic          empty;

    assign top_idx = wr_ptr - 1'b1;
    assign full    = (count == FULL_COUNT);
    assign empty   = (count == '0);
    // An empty stack hands back the reset vector so a stray return restarts cleanly
    assign top     = empty ? RESET_PC : mem[top_idx];

    // Pointer, occupancy and sticky flags
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    // Full push advances over the oldest slot, dropping it
                    wr_ptr <= wr_ptr + 1'b1;
                    if (full) begin
                        overflow <= 1'b1;
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                2'b01: begin
                    if (empty) begin
                        underflow <= 1'b1;
                    end else begin
                        wr_ptr <= wr_ptr - 1'b1;
                        count  <= count - 1'b1;
                    end
                end
                default: begin
                    // Idle, or push+pop which only rewrites the top slot
                end
            endcase
        end
    end

    // Entry storage; push+pop replaces the current top in place
    always_ff @(posedge clk) begin
        if (push && !pop) begin
            mem[wr_ptr] <= push_data;
        end else if (push && pop) begin
            mem[top_idx] <= push_data;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - MUSA instruction fetch stage; FETCH_RAS_EN builds the return-address stack
module fetch_unit
    import musa_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
    parameter int unsigned RAS_DEPTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               PCWrite,
    input  logic [1:0]         pcSrc,
    input  logic               push,
    input  logic               pop,
    input  logic               halt,
    input  logic [15:0]        branch_offset,
    input  logic [25:0]        jump_target,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               imem_ready,
`ifndef FETCH_RAS_EN
    input  logic [31:0]        reg_target,
`endif
    output logic [31:0]        imem_addr,
    output logic               imem_req,
    output logic [INSTR_W-1:0] instr,
    output logic               instr_valid,
    output logic [31:0]        pc_plus4,
    output logic               ras_overflow,
    output logic               ras_underflow
);

    fetch_state_e state;
    logic [31:0]  pc;
    logic [31:0]  pc_seq;
    logic [31:0]  next_pc;
    logic [31:0]  ret_addr;
    logic         accept;
    logic         pc_en;

    assign imem_addr = pc;
    assign imem_req  = (state == ST_FETCH);
    assign pc_seq    = pc + 32'd4;
    assign accept    = (state == ST_FETCH) && imem_ready;
    // Stack and PC move together so a stalled fetch never half-commits a call
    assign pc_en     = accept && PCWrite;

`ifdef FETCH_RAS_EN
    fetch_ras #(
        .DEPTH    (RAS_DEPTH),
        .RESET_PC (RESET_PC)
    ) u_ras (
        .clk       (clk),
        .rst       (rst),
        .push      (pc_en && push),
        .pop       (pc_en && pop),
        .push_data (pc_plus4),
        .top       (ret_addr),
        .overflow  (ras_overflow),
        .underflow (ras_underflow)
    );
`else
    logic unused_ras;
    assign unused_ras    = ^{push, pop, RAS_DEPTH};
    assign ret_addr      = reg_target;
    assign ras_overflow  = 1'b0;
    assign ras_underflow = 1'b0;
`endif

    // Next-PC select driven by the control unit
    always_comb begin
        next_pc = pc_seq;
        case (pc_src_e'(pcSrc))
            PC_SEQ:    next_pc = pc_seq;
            PC_BRANCH: next_pc = branch_addr(pc_seq, branch_offset);
            PC_JUMP:   next_pc = jump_addr(pc_seq, jump_target);
            PC_RET:    next_pc = ret_addr;
            default:   next_pc = pc_seq;
        endcase
    end

    // Fetch FSM with PC and the registered instruction/pc+4 outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= ST_BOOT;
            pc          <= RESET_PC;
            instr       <= '0;
            instr_valid <= 1'b0;
            pc_plus4    <= RESET_PC + 32'd4;
        end else begin
            instr_valid <= 1'b0;
            case (state)
                ST_BOOT: begin
                    state <= ST_FETCH;
                end
                ST_FETCH: begin
                    if (imem_ready) begin
                        instr       <= imem_rdata;
                        pc_plus4    <= pc_seq;
                        instr_valid <= 1'b1;
                        if (PCWrite) begin
                            pc <= next_pc;
                        end
                    end
                    // The word arriving with halt is still taken before stopping
                    if (halt) begin
                        state <= ST_HALTED;
                    end
                end
                ST_HALTED: begin
                    state <= ST_HALTED;
                end
                default: begin
                    state <= ST_BOOT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - self-checking bench for fetch_unit with a queue-based reference model
module tb_fetch_unit;
    import musa_fetch_pkg::*;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
`ifdef FETCH_RAS_EN
    localparam int DEPTH = 8;
`endif

    logic        clk;
    logic        rst;
    logic        PCWrite;
    logic [1:0]  pcSrc;
    logic        push;
    logic        pop;
    logic        halt;
    logic [15:0] branch_offset;
    logic [25:0] jump_target;
    logic [31:0] imem_rdata;
    logic        imem_ready;
    logic [31:0] reg_target;
    logic [31:0] imem_addr;
    logic        imem_req;
    logic [31:0] instr;
    logic        instr_valid;
    logic [31:0] pc_plus4;
    logic        ras_overflow;
    logic        ras_underflow;

    int checks = 0;
    int errors = 0;

    // reference model state
    logic [31:0] m_pc, m_instr, m_pp4;
    logic        m_valid, m_boot, m_halted, m_ovf, m_unf;
    logic [31:0] m_ras[$];

    fetch_unit #(.RESET_PC(RST_PC), .RAS_DEPTH(8)) dut (
        .clk           (clk),
        .rst           (rst),
        .PCWrite       (PCWrite),
        .pcSrc         (pcSrc),
        .push          (push),
        .pop           (pop),
        .halt          (halt),
        .branch_offset (branch_offset),
        .jump_target   (jump_target),
        .imem_rdata    (imem_rdata),
        .imem_ready    (imem_ready),
`ifndef FETCH_RAS_EN
        .reg_target    (reg_target),
`endif
        .imem_addr     (imem_addr),
        .imem_req      (imem_req),
        .instr         (instr),
        .instr_valid   (instr_valid),
        .pc_plus4      (pc_plus4),
        .ras_overflow  (ras_overflow),
        .ras_underflow (ras_underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        m_pc = RST_PC; m_instr = 32'h0; m_pp4 = RST_PC + 32'd4;
        m_valid = 1'b0; m_boot = 1'b1; m_halted = 1'b0;
        m_ovf = 1'b0; m_unf = 1'b0;
        m_ras.delete();
    endtask

    // Advance the model by one clock using the inputs currently driven
    task automatic model_step();
        logic [31:0] old_pp4, ret, nxt;
        int off;
        if (m_boot) begin
            m_boot = 1'b0; m_valid = 1'b0;
        end else if (m_halted) begin
            m_valid = 1'b0;
        end else begin
            old_pp4 = m_pp4;
            m_valid = imem_ready;
            if (imem_ready) begin
                m_instr = imem_rdata;
                m_pp4   = m_pc + 32'd4;
            end
            if (imem_ready && PCWrite) begin
`ifdef FETCH_RAS_EN
                ret = (m_ras.size() > 0) ? m_ras[$] : RST_PC;
`else
                ret = reg_target;
`endif
                off = $signed(branch_offset);
                case (pcSrc)
                    2'd0: nxt = m_pc + 32'd4;
                    2'd1: nxt = m_pc + 32'd4 + off * 4;
                    2'd2: nxt = ((m_pc + 32'd4) & 32'hF000_0000) | ({6'd0, jump_target} * 32'd4);
                    default: nxt = ret;
                endcase
`ifdef FETCH_RAS_EN
                if (push && pop) begin
                    if (m_ras.size() > 0) m_ras[m_ras.size() - 1] = old_pp4;
                end else if (push) begin
                    if (m_ras.size() == DEPTH) begin
                        void'(m_ras.pop_front());
                        m_ovf = 1'b1;
                    end
                    m_ras.push_back(old_pp4);
                end else if (pop) begin
                    if (m_ras.size() == 0) m_unf = 1'b1;
                    else void'(m_ras.pop_back());
                end
`endif
                m_pc = nxt;
            end
            if (halt) m_halted = 1'b1;
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        PCWrite = 1'b1; pcSrc = 2'b00; push = 1'b0; pop = 1'b0; halt = 1'b0;
        branch_offset = 16'h0; jump_target = 26'h0; imem_rdata = 32'h0;
        imem_ready = 1'b1; reg_target = 32'h0;
    endtask

    // Assert reset on a falling edge, release it just after the next rising edge
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        idle_inputs();
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic test_reset();
        logic [31:0] word;
        @(negedge clk);
        rst = 1'b0;
        idle_inputs();
        model_reset();
        #1;
        checks++; if (imem_addr !== RST_PC) begin errors++; $display("FAIL reset_pc got %h exp %h", imem_addr, RST_PC); end
        checks++; if (instr !== 32'h0) begin errors++; $display("FAIL reset_instr got %h exp 0", instr); end
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", instr_valid); end
        checks++; if (pc_plus4 !== RST_PC + 32'd4) begin errors++; $display("FAIL reset_pp4 got %h exp %h", pc_plus4, RST_PC + 32'd4); end
        checks++; if ({ras_overflow, ras_underflow} !== 2'b00) begin errors++; $display("FAIL reset_flags got %b exp 00", {ras_overflow, ras_underflow}); end
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req got %b exp 0", imem_req); end
        @(posedge clk);
        #1;
        rst = 1'b1;
        tick();
        checks++; if (imem_addr !== 32'h0 || instr_valid !== 1'b0) begin errors++; $display("FAIL boot_cycle addr %h valid %b exp 0 0", imem_addr, instr_valid); end
        word = $urandom;
        imem_rdata = word;
        tick();
        checks++; if (imem_addr !== 32'h4 || instr_valid !== 1'b1) begin errors++; $display("FAIL first_fetch addr %h valid %b exp 4 1", imem_addr, instr_valid); end
        checks++; if (instr !== word) begin errors++; $display("FAIL first_instr got %h exp %h", instr, word); end
        tick();
        checks++; if (imem_addr !== 32'h8) begin errors++; $display("FAIL second_fetch addr %h exp 8", imem_addr); end
    endtask

    task automatic test_branch();
        do_reset();
        tick();
        pcSrc = 2'b10; jump_target = 26'h10;
        tick();
        checks++; if (imem_addr !== 32'h40) begin errors++; $display("FAIL jump_0x40 got %h exp 40", imem_addr); end
        pcSrc = 2'b01; branch_offset = 16'hFFFF;
        tick();
        checks++; if (imem_addr !== 32'h40) begin errors++; $display("FAIL branch_self got %h exp 40", imem_addr); end
        branch_offset = 16'hFFEE;
        tick();
        checks++; if (imem_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL branch_back got %h exp fffffffc", imem_addr); end
        pcSrc = 2'b00;
        tick();
        checks++; if (imem_addr !== 32'h0 || pc_plus4 !== 32'h0) begin errors++; $display("FAIL wrap addr %h pp4 %h exp 0 0", imem_addr, pc_plus4); end
    endtask

    task automatic test_call_ret();
        do_reset();
        tick();
        pcSrc = 2'b10; jump_target = 26'h40;
        tick();
        pcSrc = 2'b00;
        tick();
        checks++; if (pc_plus4 !== 32'h104) begin errors++; $display("FAIL call_pp4 got %h exp 104", pc_plus4); end
        push = 1'b1; pcSrc = 2'b10; jump_target = 26'h80; reg_target = 32'hDEAD_0000;
        tick();
        checks++; if (imem_addr !== 32'h200) begin errors++; $display("FAIL call_target got %h exp 200", imem_addr); end
        push = 1'b0; pop = 1'b1; pcSrc = 2'b11; reg_target = 32'h104;
        tick();
        checks++; if (imem_addr !== 32'h104) begin errors++; $display("FAIL ret_target got %h exp 104", imem_addr); end
        pop = 1'b0; pcSrc = 2'b00;
    endtask

`ifdef FETCH_RAS_EN
    task automatic test_ras_limits();
        logic [31:0] exp;
        do_reset();
        tick();
        tick();
        tick();
        push = 1'b1;
        for (int i = 0; i < 9; i++) begin
            tick();
            if (i == 7) begin
                checks++; if (ras_overflow !== 1'b0) begin errors++; $display("FAIL ovf_early got %b exp 0", ras_overflow); end
            end
        end
        checks++; if (ras_overflow !== 1'b1) begin errors++; $display("FAIL ovf_set got %b exp 1", ras_overflow); end
        push = 1'b0; pop = 1'b1; pcSrc = 2'b11;
        for (int j = 0; j < 9; j++) begin
            tick();
            exp = (j < 8) ? 32'd8 + 32'd4 * (8 - j) : RST_PC;
            checks++; if (imem_addr !== exp) begin errors++; $display("FAIL pop_%0d got %h exp %h", j, imem_addr, exp); end
            checks++; if (ras_underflow !== (j == 8)) begin errors++; $display("FAIL unf_%0d got %b exp %b", j, ras_underflow, j == 8); end
        end
        pop = 1'b0; pcSrc = 2'b00;
    endtask
`endif

    task automatic test_stall();
        logic [31:0] word;
        do_reset();
        tick();
        imem_rdata = $urandom;
        tick();
        word = $urandom;
        imem_rdata = word;
        tick();
        imem_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            imem_rdata = $urandom;
            tick();
            checks++; if (imem_addr !== 32'h8 || instr !== word || instr_valid !== 1'b0)
                begin errors++; $display("FAIL stall_%0d addr %h instr %h valid %b exp 8 %h 0", k, imem_addr, instr, instr_valid, word); end
        end
        imem_ready = 1'b1;
        tick();
        checks++; if (imem_addr !== 32'hC || instr_valid !== 1'b1) begin errors++; $display("FAIL stall_resume addr %h valid %b exp c 1", imem_addr, instr_valid); end
    endtask

    task automatic test_halt();
        logic [31:0] word;
        do_reset();
        tick();
        tick();
        word = $urandom;
        imem_rdata = word; halt = 1'b1;
        tick();
        halt = 1'b0;
        checks++; if (instr_valid !== 1'b1 || instr !== word) begin errors++; $display("FAIL halt_accept valid %b instr %h exp 1 %h", instr_valid, instr, word); end
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL halt_req got %b exp 0", imem_req); end
        for (int k = 0; k < 3; k++) begin
            imem_rdata = $urandom;
            tick();
            checks++; if (imem_addr !== 32'h8 || instr_valid !== 1'b0 || imem_req !== 1'b0)
                begin errors++; $display("FAIL halted_%0d addr %h valid %b req %b exp 8 0 0", k, imem_addr, instr_valid, imem_req); end
        end
        #2;
        rst = 1'b0;
        #1;
        checks++; if (imem_addr !== RST_PC || instr !== 32'h0) begin errors++; $display("FAIL async_reset addr %h instr %h exp %h 0", imem_addr, instr, RST_PC); end
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic test_random();
        do_reset();
        tick();
        for (int n = 0; n < 500; n++) begin
            imem_ready    = ($urandom_range(3) != 0);
            PCWrite       = ($urandom_range(7) != 0);
            pcSrc         = 2'($urandom_range(3));
            push          = ($urandom_range(3) == 0);
            pop           = ($urandom_range(3) == 0);
            branch_offset = 16'($urandom);
            jump_target   = 26'($urandom);
            imem_rdata    = $urandom;
            reg_target    = $urandom & 32'hFFFF_FFFC;
            tick();
            checks++; if (imem_addr !== m_pc) begin errors++; $display("FAIL rnd_pc_%0d got %h exp %h", n, imem_addr, m_pc); end
            checks++; if (instr !== m_instr || instr_valid !== m_valid)
                begin errors++; $display("FAIL rnd_instr_%0d got %h/%b exp %h/%b", n, instr, instr_valid, m_instr, m_valid); end
            checks++; if (pc_plus4 !== m_pp4) begin errors++; $display("FAIL rnd_pp4_%0d got %h exp %h", n, pc_plus4, m_pp4); end
            checks++; if ({ras_overflow, ras_underflow} !== {m_ovf, m_unf})
                begin errors++; $display("FAIL rnd_flags_%0d got %b%b exp %b%b", n, ras_overflow, ras_underflow, m_ovf, m_unf); end
        end
        idle_inputs();
    endtask

    initial begin
        rst = 1'b0;
        idle_inputs();
        model_reset();
        test_reset();
        test_branch();
        test_call_ret();
`ifdef FETCH_RAS_EN
        test_ras_limits();
`endif
        test_stall();
        test_halt();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
